// File: rtl/icache_controller.sv
`default_nettype none
// ============================================================================
//  Module   : icache_controller
//  Purpose  : Read-only controller for one cache set: hit/miss, line fill
//             from the memory bus and invalidate-all sweep.
//  Revision : 1.0 - initial release
// ============================================================================
module icache_controller #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int TAG_WIDTH   = 3,
    parameter int INDEX_WIDTH = 5
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    input  logic                   i_rd,
    input  logic                   i_flush,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic                   o_ready,
    output logic                   o_busy,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    output logic                   o_mem_rd,
    input  logic [DATA_WIDTH-1:0]  i_mem_data,
    input  logic                   i_mem_ack,
    output logic [INDEX_WIDTH-1:0] o_set_index,
    output logic [TAG_WIDTH-1:0]   o_set_tag,
    output logic                   o_set_wr,
    output logic                   o_set_cl,
    output logic [DATA_WIDTH-1:0]  o_set_data,
    input  logic [DATA_WIDTH-1:0]  i_set_data,
    input  logic                   i_set_hit
);

    localparam int c_idx_lsb = 2;
    localparam int c_idx_msb = INDEX_WIDTH + 1;
    localparam int c_tag_lsb = INDEX_WIDTH + 2;
    localparam int c_tag_msb = INDEX_WIDTH + TAG_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FILL  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [INDEX_WIDTH-1:0] r_sweep;
    logic                   r_flush_pend;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_data;

    // Byte-lane bits never select anything in a word cache.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = &{1'b0, i_addr[1:0]};

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_INIT;
            r_sweep      <= '0;
            r_flush_pend <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_flush_pend <= 1'b0;
                    if (r_sweep == {INDEX_WIDTH{1'b1}}) begin
                        r_state <= ST_IDLE;
                        r_sweep <= '0;
                    end else begin
                        r_sweep <= r_sweep + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (i_flush) begin
                        r_state      <= ST_INIT;
                        r_sweep      <= '0;
                        r_flush_pend <= 1'b0;
                    end else if (i_rd && !i_set_hit) begin
                        r_addr  <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
                        r_state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (i_flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (i_mem_ack) begin
                        r_data  <= i_mem_data;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // A flush that arrived during the fill is honoured only once the line is written.
                    if (r_flush_pend || i_flush) begin
                        r_state      <= ST_INIT;
                        r_sweep      <= '0;
                        r_flush_pend <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    always_comb begin
        o_ready     = 1'b0;
        o_mem_rd    = 1'b0;
        o_set_wr    = 1'b0;
        o_set_cl    = 1'b0;
        o_set_index = r_addr[c_idx_msb:c_idx_lsb];
        o_set_tag   = r_addr[c_tag_msb:c_tag_lsb];
        case (r_state)
            ST_INIT: begin
                o_set_cl    = ~i_reset;
                o_set_index = r_sweep;
                o_set_tag   = '0;
            end
            ST_IDLE: begin
                o_set_index = i_addr[c_idx_msb:c_idx_lsb];
                o_set_tag   = i_addr[c_tag_msb:c_tag_lsb];
                o_ready     = ~i_reset & i_rd & i_set_hit & ~i_flush;
            end
            ST_FILL:  o_mem_rd = ~i_reset;
            ST_WRITE: o_set_wr = ~i_reset;
            default: ;
        endcase
    end

    assign o_busy     = i_reset | (r_state != ST_IDLE);
    assign o_data     = i_set_data;
    assign o_set_data = r_data;
    assign o_mem_addr = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_icache_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_controller
//  Purpose  : Self-checking bench with a cache-set model, memory responder
//             and rule-level output checker.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        rd;
    logic        flush;
    logic [31:0] o_data;
    logic        o_ready;
    logic        o_busy;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_data;
    logic        mem_ack;
    logic [4:0]  set_index;
    logic [2:0]  set_tag;
    logic        set_wr;
    logic        set_cl;
    logic [31:0] set_wdata;
    logic [31:0] set_rdata;
    logic        set_hit;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_cnt;
    int ack_delay = 0;
    int late_ack_cycle = -1;

    // monitor statistics
    int wr_cnt, cl_cnt, memrd_cnt;
    logic [4:0] last_wr_idx;
    logic [2:0] last_wr_tag;

    always #5 clk = ~clk;

    icache_controller #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TAG_WIDTH(3), .INDEX_WIDTH(5)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_addr     (addr),
        .i_rd       (rd),
        .i_flush    (flush),
        .o_data     (o_data),
        .o_ready    (o_ready),
        .o_busy     (o_busy),
        .o_mem_addr (mem_addr),
        .o_mem_rd   (mem_rd),
        .i_mem_data (mem_data),
        .i_mem_ack  (mem_ack),
        .o_set_index(set_index),
        .o_set_tag  (set_tag),
        .o_set_wr   (set_wr),
        .o_set_cl   (set_cl),
        .o_set_data (set_wdata),
        .i_set_data (set_rdata),
        .i_set_hit  (set_hit)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        case (w)
            32'h0000_0044: return 32'hDEAD_BEEF;
            32'h0000_00C4: return 32'h1234_5678;
            default:       return {w[15:0] ^ 16'hA5C3, w[15:0]};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Cache set model: starts full of stale valid lines so a missing sweep shows up.
    logic        s_valid [32];
    logic [2:0]  s_tag   [32];
    logic [31:0] s_data  [32];
    bit          s_init_done;

    always @(posedge clk) begin
        if (!s_init_done) begin
            for (int i = 0; i < 32; i++) begin
                s_valid[i] <= 1'b1;
                s_tag[i]   <= 3'd0;
                s_data[i]  <= 32'hBADC_0DE0 + i;
            end
            s_init_done <= 1'b1;
        end else if (set_cl) begin
            s_valid[set_index] <= 1'b0;
        end else if (set_wr) begin
            s_valid[set_index] <= 1'b1;
            s_tag[set_index]   <= set_tag;
            s_data[set_index]  <= set_wdata;
        end
    end

    assign set_hit   = s_init_done && s_valid[set_index] && (s_tag[set_index] == set_tag);
    assign set_rdata = s_init_done ? s_data[set_index] : 32'h0;

    // Memory responder: ack after ack_delay FILL cycles, plus an optional stray ack.
    initial begin
        int fill_cnt;
        fill_cnt = 0;
        mem_ack  = 1'b0;
        mem_data = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (mem_rd && !rst) begin
                if (fill_cnt == ack_delay) begin
                    mem_ack  = 1'b1;
                    mem_data = mem_word(mem_addr);
                    fill_cnt = 0;
                end else begin
                    fill_cnt++;
                end
            end else begin
                fill_cnt = 0;
            end
            if (cyc_cnt == late_ack_cycle) begin
                mem_ack  = 1'b1;
                mem_data = 32'hBAD0_BAD0;
            end
        end
    end

    // Rule checker, every cycle.
    always @(negedge clk) begin
        if (cyc_cnt > 0) begin
            if (rst) begin
                check("rst_ready", o_ready, 0);
                check("rst_mem_rd", mem_rd, 0);
                check("rst_set_wr", set_wr, 0);
                check("rst_set_cl", set_cl, 0);
                check("rst_busy", o_busy, 1);
            end else begin
                check("wr_cl_excl", set_wr & set_cl, 0);
                check("data_pass", o_data, set_rdata);
                if (o_busy) check("busy_no_ready", o_ready, 0);
                else if (rd && !flush) begin
                    check("idle_hit_ready", o_ready, set_hit);
                    check("idle_index", set_index, addr[6:2]);
                    check("idle_tag", set_tag, addr[9:7]);
                end
                if (o_ready) begin
                    check("ready_rd", rd, 1);
                    check("ready_data", o_data, mem_word(addr));
                end
                if (mem_rd) begin
                    check("mem_addr", mem_addr, {addr[31:2], 2'b00});
                    check("fill_no_wr", set_wr, 0);
                end
                if (set_wr) begin
                    check("wr_index", set_index, addr[6:2]);
                    check("wr_tag", set_tag, addr[9:7]);
                    check("wr_data", set_wdata, mem_word(addr));
                    wr_cnt <= wr_cnt + 1;
                    last_wr_idx <= set_index;
                    last_wr_tag <= set_tag;
                end
                if (set_cl) begin
                    check("cl_tag", set_tag, 0);
                    cl_cnt <= cl_cnt + 1;
                end
                if (mem_rd) memrd_cnt <= memrd_cnt + 1;
            end
        end
    end

    task automatic sweep_check();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check("sweep_cl", set_cl, 1);
            check("sweep_idx", set_index, i);
        end
        @(negedge clk);
        check("sweep_done_busy", o_busy, 0);
        check("sweep_done_cl", set_cl, 0);
    endtask

    task automatic do_read(input logic [31:0] a, input int d, input int flush_at,
                           output int lat, output logic [31:0] rdata);
        ack_delay = d;
        @(posedge clk);
        #1;
        addr  = a;
        rd    = 1'b1;
        lat   = -1;
        rdata = 32'hx;
        for (int k = 0; k < 300; k++) begin
            flush = (k == flush_at);
            @(negedge clk);
            if (o_ready) begin
                lat   = k;
                rdata = o_data;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        rd    = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        int lat;
        int w0, c0, m0;
        logic [31:0] rdata;
        bit seen;
        rst = 1'b1; rd = 1'b0; flush = 1'b0; addr = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", o_busy, 1);
        check("reset_cl", set_cl, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sweep_check();

        // cold miss: ack one cycle after mem_rd rises
        w0 = wr_cnt; m0 = memrd_cnt;
        do_read(32'h0000_0044, 1, -1, lat, rdata);
        check("cold_latency", lat, 4);
        check("cold_data", rdata, 32'hDEAD_BEEF);
        check("cold_wr_cnt", wr_cnt - w0, 1);
        check("cold_memrd_cnt", memrd_cnt - m0, 2);
        check("cold_idx", last_wr_idx, 17);
        check("cold_tag", last_wr_tag, 0);

        // warm hit
        m0 = memrd_cnt;
        do_read(32'h0000_0044, 1, -1, lat, rdata);
        check("warm_latency", lat, 0);
        check("warm_data", rdata, 32'hDEAD_BEEF);
        check("warm_memrd_cnt", memrd_cnt - m0, 0);

        // conflict miss, minimum latency
        do_read(32'h0000_00C4, 0, -1, lat, rdata);
        check("conf_latency", lat, 3);
        check("conf_data", rdata, 32'h1234_5678);
        check("conf_idx", last_wr_idx, 17);
        check("conf_tag", last_wr_tag, 1);
        do_read(32'h0000_0044, 2, -1, lat, rdata);
        check("reread_latency", lat, 5);
        check("reread_data", rdata, 32'hDEAD_BEEF);

        // flush during FILL: write, 32-cycle sweep, then a fresh miss
        w0 = wr_cnt; c0 = cl_cnt;
        do_read(32'h0000_0100, 5, 3, lat, rdata);
        check("fflush_latency", lat, 48);
        check("fflush_wr_cnt", wr_cnt - w0, 2);
        check("fflush_cl_cnt", cl_cnt - c0, 32);
        do_read(32'h0000_0044, 0, -1, lat, rdata);
        check("after_flush_miss", lat, 3);

        // flush in IDLE takes priority over a hitting read
        do_read(32'h0000_0100, 0, 0, lat, rdata);
        check("iflush_latency", lat, 36);

        // reset mid-FILL, with a stray ack during the new sweep
        ack_delay = 20;
        @(posedge clk);
        #1;
        addr = 32'h0000_0200;
        rd   = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_rd) begin
                seen = 1'b1;
                break;
            end
        end
        check("midfill_mem_rd_seen", seen, 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rd  = 1'b0;
        @(negedge clk);
        check("midfill_rst_mem_rd", mem_rd, 0);
        check("midfill_rst_busy", o_busy, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        late_ack_cycle = cyc_cnt + 4;
        sweep_check();
        do_read(32'h0000_0200, 0, -1, lat, rdata);
        check("post_rst_latency", lat, 3);
        check("post_rst_data", rdata, mem_word(32'h0000_0200));

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/icache_controller.md
# icache_controller

Read-only cache controller sitting directly upstream of one cache set. Takes word read requests from the fetch stage and drives the set's index, tag, write and invalidate lines. Detects hit or miss from the set's hit output. On a miss, fetches the word from the memory bus and writes it into the set. Also runs the invalidate-all sweep after reset and on a flush request.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data word width
- TAG_WIDTH, 3, tag width; must match the cache set
- INDEX_WIDTH, 5, index width; must match the cache set

Ports:
- i_clock  in  1  clock; one clock domain
- i_reset  in  1  reset; synchronous, active-high
- i_addr  in  ADDR_WIDTH  fetch byte address
  - bits [1:0] ignored
  - index = [INDEX_WIDTH+1:2]
  - tag = [INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2]
- i_rd  in  1  read request; held with i_addr stable until o_ready
- i_flush  in  1  invalidate-all request (single-cycle pulse)
- o_data  out  DATA_WIDTH  read data; valid when o_ready
- o_ready  out  1  request completed this cycle
- o_busy  out  1  controller not in IDLE
- o_mem_addr  out  ADDR_WIDTH  memory word address (bits [1:0] = 0)
- o_mem_rd  out  1  memory read request
- i_mem_data  in  DATA_WIDTH  memory read data
- i_mem_ack  in  1  memory data valid; one-cycle pulse
- o_set_index  out  INDEX_WIDTH  cache set index
- o_set_tag  out  TAG_WIDTH  cache set tag
- o_set_wr  out  1  cache set write
- o_set_cl  out  1  cache set invalidate
- o_set_data  out  DATA_WIDTH  cache set write data
- i_set_data  in  DATA_WIDTH  cache set read data
- i_set_hit  in  1  cache set hit; combinational from index/tag in the same cycle

## Operation
- FSM states: INIT, IDLE, FILL, WRITE.
- **INIT**
  - o_set_cl=1, o_set_index=sweep counter, o_set_tag=0.
  - Counter runs 0 .. 2^INDEX_WIDTH-1.
  - After the last index, go to IDLE; counter clears to 0.
- **IDLE**
  - o_set_index/o_set_tag come combinationally from i_addr.
  - i_rd & i_set_hit: o_ready=1, o_data=i_set_data; stay in IDLE.
  - i_rd & ~i_set_hit:
    - latch i_addr (bits [1:0] forced to 0) into the address register;
    - go to FILL.
  - i_flush has priority over i_rd. It goes to INIT, and o_ready stays 0 that cycle.
- **FILL**
  - o_mem_rd=1; o_mem_addr=latched address.
  - o_set_index/o_set_tag come from the latched address; o_set_wr=0.
  - On i_mem_ack: capture i_mem_data into the data register; go to WRITE.
- **WRITE**
  - o_set_wr=1, o_set_data=data register, index/tag from the latched address.
  - Then go to IDLE, where the held request hits.
- o_mem_rd is deasserted in WRITE and is never asserted outside FILL.
- i_flush seen in FILL or WRITE:
  - set a pending flag;
  - the fill completes normally;
  - WRITE then goes to INIT instead of IDLE;
  - the flag is cleared on entry to INIT.
- i_flush during INIT: ignored, no sweep restart.
- i_mem_ack outside FILL: ignored.
- o_set_wr and o_set_cl are never both 1.
- o_data is a combinational pass-through of i_set_data at all times; it is meaningful only while o_ready=1.
- o_busy = (state != IDLE).

## Timing
- While i_reset=1:
  - all outputs forced: o_ready=0, o_mem_rd=0, o_set_wr=0, o_set_cl=0, o_busy=1;
  - the pending flag clears.
- First cycle after reset: INIT with index 0. This applies from any state, including mid-FILL.
- A mid-FILL reset abandons the memory request; the memory bus must accept a dropped o_mem_rd.
- Sweep length: exactly 2^INDEX_WIDTH cycles with o_set_cl=1. First IDLE cycle is reset-release + 2^INDEX_WIDTH.
- Hit latency: 0 cycles; o_ready is in the same cycle as i_rd.
- Miss latency, with the miss seen in cycle 0:
  - FILL from cycle 1;
  - ack in cycle t (t ≥ 1);
  - WRITE in cycle t+1;
  - o_ready in cycle t+2.
- Minimum miss latency: 3 cycles (ack in the first FILL cycle).
- o_mem_addr is stable throughout FILL.

## Test plan
- **Reset sweep:** release reset.
  - o_set_cl=1 for 32 cycles on indices 0..31 in order;
  - o_busy=0 in cycle 33.
- **Cold miss:** i_rd, i_addr=0x0000_0044; memory acks one cycle after o_mem_rd with 0xDEAD_BEEF.
  - o_mem_addr=0x44; index 17, tag 0;
  - one o_set_wr cycle;
  - then o_ready=1 with o_data=0xDEAD_BEEF.
- **Warm hit:** repeat the read of 0x44.
  - o_ready=1 in the same cycle;
  - o_mem_rd stays 0.
- **Conflict miss:** read 0x0000_00C4 (index 17, tag 1) with memory data 0x1234_5678.
  - refill with o_set_tag=1;
  - a re-read of 0x44 then misses again.
- **Flush during FILL:** assert i_flush while waiting 5 cycles for ack.
  - fill completes;
  - WRITE is followed by a 32-cycle INIT;
  - o_ready for the held request arrives only after the sweep, via a new miss.
- **Reset mid-FILL:** assert i_reset while o_mem_rd=1.
  - o_mem_rd=0 during reset;
  - a fresh 32-cycle sweep follows;
  - a late i_mem_ack during INIT is ignored.
